// File: rtl/accumulator_16bit_pkg.sv
// rtl/accumulator_16bit_pkg.sv - state encodings and data width shared by the arithmetic-lab blocks
package accumulator_16bit_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/carry_select_16bit.sv
// rtl/carry_select_16bit.sv - 16-bit carry-select adder built from 4-bit blocks
module carry_select_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);

  logic [4:0] carry;

  assign carry[0] = cin;

  // Each block precomputes both carry-in cases; the incoming carry only selects.
  for (genvar i = 0; i < 4; i++) begin : g_blk
    logic [4:0] s0;
    logic [4:0] s1;

    assign s0 = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]};
    assign s1 = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + 5'd1;

    assign sum[4*i +: 4] = carry[i] ? s1[3:0] : s0[3:0];
    assign carry[i+1]    = carry[i] ? s1[4]   : s0[4];
  end

  assign cout = carry[4];

endmodule

// File: rtl/accumulator_16bit.sv
// rtl/accumulator_16bit.sv - multi-operand stream accumulator with sticky unsigned overflow
module accumulator_16bit
  import accumulator_16bit_pkg::*;
#(
  parameter int LEN_W = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_sum,
  output logic              out_ovf,
  output logic              busy
);

  state_t             state, state_next;
  logic [DATA_W-1:0]  acc, acc_next;
  logic               ovf, ovf_next;
  logic [LEN_W-1:0]   remaining, remaining_next;
  logic [DATA_W-1:0]  add_sum;
  logic               add_cout;

  carry_select_16bit u_adder (
    .a    (acc),
    .b    (in_data),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      acc       <= '0;
      ovf       <= 1'b0;
      remaining <= '0;
    end else begin
      state     <= state_next;
      acc       <= acc_next;
      ovf       <= ovf_next;
      remaining <= remaining_next;
    end
  end

  always_comb begin
    state_next     = state;
    acc_next       = acc;
    ovf_next       = ovf;
    remaining_next = remaining;
    case (state)
      ST_IDLE: begin
        if (start) begin
          acc_next = '0;
          ovf_next = 1'b0;
          if (len != '0) begin
            remaining_next = len;
            state_next     = ST_ACCUM;
          end else begin
            state_next     = ST_DONE;
          end
        end
      end
      ST_ACCUM: begin
        if (in_valid) begin
          acc_next       = add_sum;
          ovf_next       = ovf | add_cout;
          remaining_next = remaining - LEN_W'(1);
          if (remaining == LEN_W'(1)) state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        // A start coinciding with out_ready is dropped: it is only sampled in IDLE.
        if (out_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign in_ready  = (state == ST_ACCUM);
  assign out_valid = (state == ST_DONE);
  assign busy      = (state != ST_IDLE);
  assign out_sum   = (state == ST_DONE) ? acc : '0;
  assign out_ovf   = (state == ST_DONE) ? ovf : 1'b0;

endmodule
